// File: rtl/keypad_scan.sv
// keypad_scan - 4x4 matrix keypad scanner with press/release debounce.
//
// Drives one row low at a time, synchronises the column returns and, when a
// single key is seen, freezes the row and debounces the press. An accepted press
// updates oKEY and pulses oVALID once; oHELD stays high until the release is
// debounced, after which scanning resumes on the next row. Chords are rejected.
//
// Optional feature (macro KEY_REPEAT_EN): while a key stays held, oVALID
// re-pulses after REP_DLY cycles and then every REP_RATE cycles. Without the
// macro no repeat logic exists and REP_DLY/REP_RATE are ignored.
//
// Ports:
//   iCLK    scan clock (divided slow clock), rising edge
//   RSTB    asynchronous active-low reset
//   iCOL    column returns, active-low, asynchronous to iCLK
//   oROW    row drive, active-low, exactly one bit low
//   oKEY    last accepted key code {row[1:0], col[1:0]}
//   oVALID  one-cycle strobe on accept (and on auto-repeat)
//   oHELD   high from press accept until release accept

module keypad_scan #(
  parameter int unsigned SETTLE   = 4,     // 3..15
  parameter int unsigned DEB_CNT  = 600,
  parameter int unsigned REP_DLY  = 16384,
  parameter int unsigned REP_RATE = 3333
) (
  input  logic       iCLK,
  input  logic       RSTB,
  input  logic [3:0] iCOL,
  output logic [3:0] oROW,
  output logic [3:0] oKEY,
  output logic       oVALID,
  output logic       oHELD
);

  localparam logic [3:0]  SettleLast = 4'(SETTLE - 1);
  localparam logic [15:0] DebTarget  = 16'(DEB_CNT);

  typedef enum logic [1:0] {StScan, StDebounce, StHold} state_e;

  // Column synchroniser
  logic [3:0] colMeta, sc;

  always_ff @(posedge iCLK or negedge RSTB) begin
    if (!RSTB) begin
      colMeta <= 4'hF;
      sc      <= 4'hF;
    end else begin
      colMeta <= iCOL;
      sc      <= colMeta;
    end
  end

  // Single-key detection on the synchronised columns
  logic       singleLow;
  logic [1:0] scCol;

  always_comb begin
    singleLow = 1'b0;
    scCol     = 2'd0;
    case (sc)
      4'b1110: begin singleLow = 1'b1; scCol = 2'd0; end
      4'b1101: begin singleLow = 1'b1; scCol = 2'd1; end
      4'b1011: begin singleLow = 1'b1; scCol = 2'd2; end
      4'b0111: begin singleLow = 1'b1; scCol = 2'd3; end
      default: ;
    endcase
  end

  state_e      stateQ, stateD;
  logic [1:0]  rowIdxQ, rowIdxD;
  logic [1:0]  colIdxQ, colIdxD;
  logic [3:0]  patQ, patD;
  logic [3:0]  dwellQ, dwellD;
  logic [15:0] debCntQ, debCntD;
  logic [3:0]  keyQ, keyD;
  logic        validQ, validD;
  logic        heldQ, heldD;
  logic [3:0]  rowQ, rowD;

  logic [1:0]  rowNext;
  logic [15:0] debCntSat;

  assign rowNext   = rowIdxQ + 2'd1;
  assign debCntSat = (debCntQ == 16'hFFFF) ? debCntQ : debCntQ + 16'd1;

`ifdef KEY_REPEAT_EN
  localparam logic [15:0] RepDlyTarget  = 16'(REP_DLY);
  localparam logic [15:0] RepRateTarget = 16'(REP_RATE);

  logic [15:0] repCntQ, repCntD;
  logic        repPhaseQ, repPhaseD;  // 0: waiting initial delay, 1: repeating
  logic [15:0] repCntSat;

  assign repCntSat = (repCntQ == 16'hFFFF) ? repCntQ : repCntQ + 16'd1;

  always_ff @(posedge iCLK or negedge RSTB) begin
    if (!RSTB) begin
      repCntQ   <= 16'd0;
      repPhaseQ <= 1'b0;
    end else begin
      repCntQ   <= repCntD;
      repPhaseQ <= repPhaseD;
    end
  end
`else
  // Keeps the repeat parameters referenced when the feature is compiled out
  logic unusedRepParams;
  assign unusedRepParams = ^{32'(REP_DLY), 32'(REP_RATE)};
`endif

  always_comb begin
    stateD  = stateQ;
    rowIdxD = rowIdxQ;
    colIdxD = colIdxQ;
    patD    = patQ;
    dwellD  = dwellQ;
    debCntD = debCntQ;
    keyD    = keyQ;
    validD  = 1'b0;
    heldD   = heldQ;
`ifdef KEY_REPEAT_EN
    repCntD   = repCntQ;
    repPhaseD = repPhaseQ;
`endif

    unique case (stateQ)
      StScan: begin
        if (dwellQ >= SettleLast) begin
          dwellD = 4'd0;
          if (singleLow) begin
            // Row stays frozen while the press is debounced
            colIdxD = scCol;
            patD    = sc;
            debCntD = 16'd0;
            stateD  = StDebounce;
          end else begin
            rowIdxD = rowNext;
          end
        end else begin
          dwellD = dwellQ + 4'd1;
        end
      end

      StDebounce: begin
        if (sc == patQ) begin
          if (debCntSat >= DebTarget) begin
            keyD    = {rowIdxQ, colIdxQ};
            validD  = 1'b1;
            heldD   = 1'b1;
            debCntD = 16'd0;
            stateD  = StHold;
`ifdef KEY_REPEAT_EN
            repCntD   = 16'd0;
            repPhaseD = 1'b0;
`endif
          end else begin
            debCntD = debCntSat;
          end
        end else begin
          // Bounce or a second key: abandon silently and move on
          rowIdxD = rowNext;
          dwellD  = 4'd0;
          debCntD = 16'd0;
          stateD  = StScan;
        end
      end

      StHold: begin
        // debCnt doubles as the release counter here
        if (sc == 4'hF) begin
          if (debCntSat >= DebTarget) begin
            heldD   = 1'b0;
            rowIdxD = rowNext;
            dwellD  = 4'd0;
            debCntD = 16'd0;
            stateD  = StScan;
          end else begin
            debCntD = debCntSat;
          end
        end else begin
          debCntD = 16'd0;
        end
`ifdef KEY_REPEAT_EN
        if (sc == patQ) begin
          if (repCntSat >= (repPhaseQ ? RepRateTarget : RepDlyTarget)) begin
            validD    = 1'b1;
            repCntD   = 16'd0;
            repPhaseD = 1'b1;
          end else begin
            repCntD = repCntSat;
          end
        end else begin
          repCntD   = 16'd0;
          repPhaseD = 1'b0;
        end
`endif
      end

      default: begin
        stateD  = StScan;
        rowIdxD = 2'd0;
        dwellD  = 4'd0;
        debCntD = 16'd0;
      end
    endcase

    // Registered row drive avoids decode glitches on the keypad lines
    rowD = ~(4'b0001 << rowIdxD);
  end

  always_ff @(posedge iCLK or negedge RSTB) begin
    if (!RSTB) begin
      stateQ  <= StScan;
      rowIdxQ <= 2'd0;
      colIdxQ <= 2'd0;
      patQ    <= 4'hF;
      dwellQ  <= 4'd0;
      debCntQ <= 16'd0;
      keyQ    <= 4'd0;
      validQ  <= 1'b0;
      heldQ   <= 1'b0;
      rowQ    <= 4'b1110;
    end else begin
      stateQ  <= stateD;
      rowIdxQ <= rowIdxD;
      colIdxQ <= colIdxD;
      patQ    <= patD;
      dwellQ  <= dwellD;
      debCntQ <= debCntD;
      keyQ    <= keyD;
      validQ  <= validD;
      heldQ   <= heldD;
      rowQ    <= rowD;
    end
  end

  assign oROW   = rowQ;
  assign oKEY   = keyQ;
  assign oVALID = validQ;
  assign oHELD  = heldQ;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan (SETTLE=3, DEB_CNT=4,
// REP_DLY=10, REP_RATE=5). Edge numbers in comments count rising edges since
// the most recent reset release; each check samples 1 ns after that edge.

module tb_keypad_scan;

`ifdef KEY_REPEAT_EN
  localparam logic RepOn = 1'b1;
`else
  localparam logic RepOn = 1'b0;
`endif

  logic       iCLK;
  logic       RSTB;
  logic [3:0] iCOL;
  logic [3:0] oROW;
  logic [3:0] oKEY;
  logic       oVALID;
  logic       oHELD;

  // Key model: pressPat appears on the columns while row pressRow is driven;
  // forceEn overrides the columns regardless of the row (bounces, releases).
  logic       pressEn;
  logic [1:0] pressRow;
  logic [3:0] pressPat;
  logic       forceEn;
  logic [3:0] forceVal;

  int numChecks = 0;
  int numFail   = 0;
  int validCount = 0;

  keypad_scan #(
    .SETTLE  (3),
    .DEB_CNT (4),
    .REP_DLY (10),
    .REP_RATE(5)
  ) dut (
    .iCLK  (iCLK),
    .RSTB  (RSTB),
    .iCOL  (iCOL),
    .oROW  (oROW),
    .oKEY  (oKEY),
    .oVALID(oVALID),
    .oHELD (oHELD)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always_comb begin
    iCOL = 4'hF;
    if (forceEn) iCOL = forceVal;
    else if (pressEn && !oROW[pressRow]) iCOL = pressPat;
  end

  always @(negedge iCLK) begin
    if (oVALID === 1'b1) validCount++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    numChecks++;
    assert (obs === exp) else begin
      numFail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RSTB = 1'b0;
    pressEn = 1'b0; pressRow = 2'd0; pressPat = 4'hF;
    forceEn = 1'b0; forceVal = 4'hF;

    // 1. Reset values, then free-running row rotation
    tick(3);
    check("rst_row", 8'(oROW), 8'hE);
    check("rst_key", 8'(oKEY), 8'h0);
    check("rst_valid", 8'(oVALID), 8'h0);
    check("rst_held", 8'(oHELD), 8'h0);
    RSTB = 1'b1;
    tick(2);  check("scan_row_e2", 8'(oROW), 8'hE);
    tick(1);  check("scan_row_e3", 8'(oROW), 8'hD);
    tick(3);  check("scan_row_e6", 8'(oROW), 8'hB);
    tick(3);  check("scan_row_e9", 8'(oROW), 8'h7);
    tick(3);  check("scan_row_e12", 8'(oROW), 8'hE);

    // 2. Key row2 col1: row2 at edge 18, sampled at 21, accepted at 25
    pressEn = 1'b1; pressRow = 2'd2; pressPat = 4'b1101;
    tick(12); check("t2_novalid_e24", 8'(oVALID), 8'h0);
    check("t2_row_frozen_e24", 8'(oROW), 8'hB);
    tick(1);  check("t2_valid_e25", 8'(oVALID), 8'h1);
    check("t2_key_e25", 8'(oKEY), 8'h9);
    check("t2_held_e25", 8'(oHELD), 8'h1);
    tick(1);  check("t2_valid_off_e26", 8'(oVALID), 8'h0);
    tick(1);  pressEn = 1'b0;  // release after edge 27
    tick(5);  check("t2_held_e32", 8'(oHELD), 8'h1);
    check("t2_row_e32", 8'(oROW), 8'hB);
    tick(1);  check("t2_held_fall_e33", 8'(oHELD), 8'h0);
    check("t2_row_resume_e33", 8'(oROW), 8'h7);
    check("t2_valid_count", 8'(validCount), 8'd1);

    // 3. Same key, bounces open after two debounce matches
    pressEn = 1'b1;
    tick(12); check("t3_row_frozen_e45", 8'(oROW), 8'hB);
    forceEn = 1'b1; forceVal = 4'hF;
    tick(2);  check("t3_row_frozen_e47", 8'(oROW), 8'hB);
    tick(1);  check("t3_row_resume_e48", 8'(oROW), 8'h7);
    check("t3_valid_count", 8'(validCount), 8'd1);
    check("t3_key_kept", 8'(oKEY), 8'h9);
    pressEn = 1'b0; forceEn = 1'b0;

    // 4. Chord on row 1 is rejected and scanning continues
    pressEn = 1'b1; pressRow = 2'd1; pressPat = 4'b1100;
    tick(6);  check("t4_row_e54", 8'(oROW), 8'hD);
    tick(3);  check("t4_row_e57", 8'(oROW), 8'hB);
    tick(12); check("t4_row_e69", 8'(oROW), 8'hB);
    check("t4_valid_count", 8'(validCount), 8'd1);
    check("t4_held", 8'(oHELD), 8'h0);
    pressEn = 1'b0;

    // 5. Key row1 col2, accepted at 85, then a bouncy release
    pressEn = 1'b1; pressRow = 2'd1; pressPat = 4'b1011;
    tick(16); check("t5_valid_e85", 8'(oVALID), 8'h1);
    check("t5_key_e85", 8'(oKEY), 8'h6);
    check("t5_row_e85", 8'(oROW), 8'hD);
    tick(1);  forceEn = 1'b1; forceVal = 4'hF;   // high 3
    tick(3);  forceVal = 4'b1011;                // low 1
    tick(1);  forceVal = 4'hF;                   // high from here
    tick(1);  check("t5_held_e91", 8'(oHELD), 8'h1);
    tick(4);  check("t5_held_e95", 8'(oHELD), 8'h1);
    tick(1);  check("t5_held_fall_e96", 8'(oHELD), 8'h0);
    check("t5_row_e96", 8'(oROW), 8'hB);
    check("t5_valid_count1", 8'(validCount), 8'd2);
    forceEn = 1'b0;                              // second press of the same key
    tick(16); check("t5_valid2_e112", 8'(oVALID), 8'h1);
    check("t5_key2_e112", 8'(oKEY), 8'h6);
    tick(1);  pressEn = 1'b0;
    tick(5);  check("t5_held_e118", 8'(oHELD), 8'h1);
    tick(1);  check("t5_held_fall_e119", 8'(oHELD), 8'h0);
    check("t5_valid_count2", 8'(validCount), 8'd3);

    // 6. Reset while debouncing key row2 col3, then hold that key
    pressEn = 1'b1; pressRow = 2'd2; pressPat = 4'b0111;
    tick(4);  check("t6_debounce_row", 8'(oROW), 8'hB);
    check("t6_debounce_novalid", 8'(oVALID), 8'h0);
    RSTB = 1'b0;
    #1;
    check("t6_rst_row", 8'(oROW), 8'hE);
    check("t6_rst_key", 8'(oKEY), 8'h0);
    check("t6_rst_valid", 8'(oVALID), 8'h0);
    check("t6_rst_held", 8'(oHELD), 8'h0);
    tick(2);  check("t6_rst_row_held", 8'(oROW), 8'hE);
    RSTB = 1'b1;
    tick(12); check("t6_novalid_e12", 8'(oVALID), 8'h0);
    check("t6_row_e12", 8'(oROW), 8'hB);
    tick(1);  check("t6_valid_e13", 8'(oVALID), 8'h1);
    check("t6_key_e13", 8'(oKEY), 8'hB);
    check("t6_held_e13", 8'(oHELD), 8'h1);
    tick(9);  check("t6_valid_e22", 8'(oVALID), 8'h0);
    tick(1);  check("t6_rep_e23", 8'(oVALID), 8'(RepOn));
    tick(1);  check("t6_valid_e24", 8'(oVALID), 8'h0);
    tick(4);  check("t6_rep_e28", 8'(oVALID), 8'(RepOn));
    tick(5);  check("t6_rep_e33", 8'(oVALID), 8'(RepOn));
    check("t6_key_unchanged", 8'(oKEY), 8'hB);
    tick(2);  pressEn = 1'b0;  // release after edge 35
    tick(5);  check("t6_held_e40", 8'(oHELD), 8'h1);
    tick(1);  check("t6_held_fall_e41", 8'(oHELD), 8'h0);
    check("t6_row_e41", 8'(oROW), 8'h7);
    check("t6_valid_count", 8'(validCount), RepOn ? 8'd7 : 8'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFail);
    $finish;
  end

endmodule
